glitch_clk_burst: RTL and testbench

// - Parametrised successor to the single-cycle clock upset block.
// - On a trigger it waits a programmable delay, then corrupts the target clock.

---
 rtl/glitch_pkg.sv | 50 +++++
 rtl/glitch_trig_sync.sv | 38 +++
 rtl/glitch_clk_burst.sv | 203 ++++++++++++++++++++
 tb/tb_glitch_clk_burst.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared types and constants for the burst clock glitcher
//
// Purpose : glitch mode / FSM state enums, synchroniser depth floor and the
//           LFSR tap table used by the optional delay jitter.
// Ports   : none (package)
package glitch_pkg;

  typedef enum logic [1:0] {
    MODE_LOW  = 2'd0,
    MODE_HIGH = 2'd1,
    MODE_INV  = 2'd2,
    MODE_FAST = 2'd3
  } glitch_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    DELAY  = 3'd2,
    GLITCH = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } glitch_state_t;

  localparam int SYNC_STAGES_MIN = 2;

  // Feedback tap masks (bit n-1 = stage n) for maximal-length Fibonacci LFSRs.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      2:       taps = 32'h0000_0003;
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      default: taps = 32'h0000_000C;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/glitch_trig_sync.sv
// rtl/glitch_trig_sync.sv - trigger synchroniser with rising-edge pulse
//
// Purpose : brings the asynchronous trigger into the clk domain through a
//           flop chain and emits a one-cycle pulse on its rising edge.
// Ports   : clk     in  fast clock
//           rst_n   in  asynchronous active-low reset (chain cleared to 0)
//           i_async in  asynchronous trigger
//           o_rise  out one-cycle rising-edge pulse (combinational from flops)
module glitch_trig_sync
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  // Depth below two would leave a metastable flop feeding logic.
  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [STAGES-1:0] r_sync;
  logic              r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_last <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_last;

endmodule

// File: rtl/glitch_clk_burst.sv
// rtl/glitch_clk_burst.sv - programmable burst clock glitch injector
//
// Purpose : after a trigger and a programmable delay, replaces the target
//           clock with a glitch source for cfg_width cycles, repeated
//           cfg_reps times with cfg_gap clean cycles in between.
// Macro   : GLITCH_BURST_JITTER_EN adds a free-running LFSR offset to the delay.
// Ports   : clk, rst_n            fast clock, async active-low reset
//           trig, arm             async trigger, one-cycle arm pulse
//           cfg_delay/width/gap/reps/mode   burst configuration (latched on trigger)
//           clean_target_clock    undisturbed target clock
//           clk_o                 clock to target
//           armed, busy, done     status (done is a one-cycle pulse)
module glitch_clk_burst
  import glitch_pkg::*;
#(
  parameter int DELAY_W     = 16,
  parameter int WIDTH_W     = 8,
  parameter int REP_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int JITTER_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig,
  input  logic               arm,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [WIDTH_W-1:0] cfg_gap,
  input  logic [REP_W-1:0]   cfg_reps,
  input  logic [1:0]         cfg_mode,
  input  logic               clean_target_clock,
  output logic               clk_o,
  output logic               armed,
  output logic               busy,
  output logic               done
);

  glitch_state_t      r_state;
  glitch_mode_t       r_mode;
  logic               r_sel;
  logic               r_armed;
  logic               r_busy;
  logic               r_done;
  logic [DELAY_W-1:0] r_dcnt;
  logic [WIDTH_W-1:0] r_wcnt;
  logic [WIDTH_W-1:0] r_gcnt;
  logic [REP_W-1:0]   r_rcnt;
  logic [WIDTH_W-1:0] r_width;
  logic [WIDTH_W-1:0] r_gap;

  logic               w_trig_rise;
  logic [JITTER_W-1:0] w_jitter;
  logic [DELAY_W:0]   w_dly_sum;
  logic [DELAY_W-1:0] w_dly_load;
  logic               w_src;

  glitch_trig_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (trig),
    .o_rise  (w_trig_rise)
  );

`ifdef GLITCH_BURST_JITTER_EN
  localparam logic [31:0] LFSR_TAPS = lfsr_taps(JITTER_W);

  logic [JITTER_W-1:0] r_lfsr;

  // Seeded all-ones so the jitter sequence is identical after every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '1;
    end else begin
      r_lfsr <= {r_lfsr[JITTER_W-2:0], ^(r_lfsr & LFSR_TAPS[JITTER_W-1:0])};
    end
  end

  assign w_jitter = r_lfsr;
`else
  assign w_jitter = '0;
`endif

  // Delay load saturates rather than wrapping when jitter is added.
  assign w_dly_sum  = {1'b0, cfg_delay} + {{(DELAY_W+1-JITTER_W){1'b0}}, w_jitter};
  assign w_dly_load = w_dly_sum[DELAY_W] ? {DELAY_W{1'b1}} : w_dly_sum[DELAY_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode  <= MODE_LOW;
      r_sel   <= 1'b0;
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dcnt  <= '0;
      r_wcnt  <= '0;
      r_gcnt  <= '0;
      r_rcnt  <= '0;
      r_width <= '0;
      r_gap   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (arm) begin
            r_state <= ARMED;
            r_armed <= 1'b1;
          end
        end
        ARMED: begin
          if (w_trig_rise) begin
            r_state <= DELAY;
            r_armed <= 1'b0;
            r_busy  <= 1'b1;
            r_mode  <= glitch_mode_t'(cfg_mode);
            r_width <= cfg_width;
            r_gap   <= cfg_gap;
            // rcnt counts the glitches still to come after the current one.
            r_rcnt  <= (cfg_reps == '0) ? '0 : cfg_reps - 1'b1;
            r_dcnt  <= w_dly_load;
          end
        end
        DELAY: begin
          if (r_dcnt == '0) begin
            if (r_width == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= GLITCH;
              r_sel   <= 1'b1;
              r_wcnt  <= r_width - 1'b1;
            end
          end else begin
            r_dcnt <= r_dcnt - 1'b1;
          end
        end
        GLITCH: begin
          if (r_wcnt == '0) begin
            if (r_rcnt != '0) begin
              r_rcnt <= r_rcnt - 1'b1;
              if (r_gap == '0) begin
                // Zero gap: stay in GLITCH with sel held so windows merge.
                r_wcnt <= r_width - 1'b1;
              end else begin
                r_state <= GAP;
                r_sel   <= 1'b0;
                r_gcnt  <= r_gap - 1'b1;
              end
            end else begin
              r_state <= DONE;
              r_sel   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end
        GAP: begin
          if (r_gcnt == '0) begin
            r_state <= GLITCH;
            r_sel   <= 1'b1;
            r_wcnt  <= r_width - 1'b1;
          end else begin
            r_gcnt <= r_gcnt - 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= 1'b0;
          r_armed <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_src = clean_target_clock;
    case (r_mode)
      MODE_LOW:  w_src = 1'b0;
      MODE_HIGH: w_src = 1'b1;
      MODE_INV:  w_src = ~clean_target_clock;
      MODE_FAST: w_src = clk;
      default:   w_src = clean_target_clock;
    endcase
  end

  // Combinational mux; sel clears asynchronously so reset restores the clean clock at once.
  assign clk_o = r_sel ? w_src : clean_target_clock;
  assign armed = r_armed;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_glitch_clk_burst.sv
// tb/tb_glitch_clk_burst.sv - self-checking bench for glitch_clk_burst
module tb_glitch_clk_burst;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic        arm;
  logic [15:0] cfg_delay;
  logic [7:0]  cfg_width;
  logic [7:0]  cfg_gap;
  logic [3:0]  cfg_reps;
  logic [1:0]  cfg_mode;
  logic        clean;
  logic        clk_o;
  logic        armed;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d;
    int w;
    int g;
    int r;
    int m;
    int retrig;
  } vec_t;

  typedef struct {
    logic win;
    logic armed;
    logic busy;
    logic done;
    int   mode;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  glitch_clk_burst #(
    .DELAY_W     (16),
    .WIDTH_W     (8),
    .REP_W       (4),
    .SYNC_STAGES (2),
    .JITTER_W    (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .trig               (trig),
    .arm                (arm),
    .cfg_delay          (cfg_delay),
    .cfg_width          (cfg_width),
    .cfg_gap            (cfg_gap),
    .cfg_reps           (cfg_reps),
    .cfg_mode           (cfg_mode),
    .clean_target_clock (clean),
    .clk_o              (clk_o),
    .armed              (armed),
    .busy               (busy),
    .done               (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clean = 1'b0;
    forever begin
      @(negedge clk);
      clean = ~clean;
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected target clock, sampled just after a posedge (fast clk is high then).
  function automatic logic exp_clk(input logic win, input int mode);
    if (!win) return clean;
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ~clean;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_quiet(input string name);
    check1({name, "_clk"}, clk_o, clean);
    check1({name, "_armed"}, armed, 1'b0);
    check1({name, "_busy"}, busy, 1'b0);
    check1({name, "_done"}, done, 1'b0);
  endtask

  task automatic run_burst(input int idx, input vec_t v);
    int   reff;
    int   start;
    int   donek;
    exp_t e;
    cfg_delay = 16'(v.d);
    cfg_width = 8'(v.w);
    cfg_gap   = 8'(v.g);
    cfg_reps  = 4'(v.r);
    cfg_mode  = 2'(v.m);
    arm = 1'b1;
    tick();
    arm  = 1'b0;
    trig = 1'b1;
    // Trig sampled at T0; trigger detected at T0+2; first glitch at T0+3+delay.
    reff  = (v.r == 0) ? 1 : v.r;
    start = 3 + v.d;
    donek = (v.w == 0) ? start : start + reff * v.w + (reff - 1) * v.g;
    for (int k = 0; k <= donek + 3; k++) begin
      e.win   = (v.w != 0) && (k >= start) && (k < donek) && (((k - start) % (v.w + v.g)) < v.w);
      e.armed = (k < 2);
      e.busy  = (k >= 2) && (k < donek);
      e.done  = (k == donek);
      e.mode  = v.m;
      sb.push_back(e);
    end
    for (int k = 0; k <= donek + 3; k++) begin
      tick();
      if (k == 3) begin
        cfg_delay = 16'($urandom_range(0, 50));
        cfg_width = 8'($urandom_range(0, 9));
        cfg_gap   = 8'($urandom_range(0, 9));
        cfg_reps  = 4'($urandom_range(0, 15));
        cfg_mode  = 2'($urandom_range(0, 3));
      end
      if (v.retrig != 0 && k == v.retrig) trig = 1'b0;
      if (v.retrig != 0 && k == v.retrig + 3) trig = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL v%0d_k%0d_sb_empty actual=0 required=1", idx, k);
      end else begin
        e = sb.pop_front();
        check1($sformatf("v%0d_k%0d_clk", idx, k), clk_o, exp_clk(e.win, e.mode));
        check1($sformatf("v%0d_k%0d_armed", idx, k), armed, e.armed);
        check1($sformatf("v%0d_k%0d_busy", idx, k), busy, e.busy);
        check1($sformatf("v%0d_k%0d_done", idx, k), done, e.done);
      end
    end
    trig = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    vec_t extra;
    vecs[0] = '{d: 5, w: 3, g: 0, r: 1, m: 0, retrig: 0};
    vecs[1] = '{d: 2, w: 2, g: 4, r: 3, m: 2, retrig: 0};
    vecs[2] = '{d: 4, w: 0, g: 1, r: 2, m: 1, retrig: 0};
    vecs[3] = '{d: 0, w: 1, g: 0, r: 3, m: 1, retrig: 0};
    vecs[4] = '{d: 3, w: 2, g: 1, r: 0, m: 3, retrig: 0};
    vecs[5] = '{d: 1, w: 4, g: 2, r: 2, m: 0, retrig: 4};

    rst_n = 1'b0;
    trig = 1'b0;
    arm = 1'b0;
    cfg_delay = '0;
    cfg_width = '0;
    cfg_gap = '0;
    cfg_reps = '0;
    cfg_mode = '0;
    repeat (2) tick();
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Trigger without arm: nothing happens.
    cfg_delay = 16'd1;
    cfg_width = 8'd2;
    cfg_mode  = 2'd1;
    trig = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_quiet($sformatf("noarm_k%0d", k));
    end
    trig = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 6; i++) run_burst(i, vecs[i]);

    // Arm coinciding with the detected trigger edge: only the arm takes effect.
    trig = 1'b1;
    tick();
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check1($sformatf("armtrig_k%0d_armed", k), armed, 1'b1);
      check1($sformatf("armtrig_k%0d_busy", k), busy, 1'b0);
      tick();
    end
    trig = 1'b0;
    repeat (4) tick();
    extra = '{d: 2, w: 3, g: 2, r: 2, m: 2, retrig: 0};
    run_burst(6, extra);

    // Reset in the middle of a hold-high glitch window.
    cfg_delay = 16'd0;
    cfg_width = 8'd8;
    cfg_gap   = 8'd0;
    cfg_reps  = 4'd1;
    cfg_mode  = 2'd1;
    arm = 1'b1;
    tick();
    arm  = 1'b0;
    trig = 1'b1;
    repeat (6) tick();
    check1("midrst_pre_clk", clk_o, 1'b1);
    check1("midrst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_quiet("midrst_asserted");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_quiet($sformatf("midrst_after_k%0d", k));
    end
    trig = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
